// File: rtl/svlib_stream_pkg.sv
// Shared definitions for SVLib streaming blocks.
// Contents:
//   SKID_STATE_W          width of the skid-buffer state encoding
//   ST_ENC_EMPTY/BUSY/FULL  state encodings reused by other stream blocks
//   skid_state_t          occupancy state of a 2-entry register slice
package svlib_stream_pkg;

  localparam int unsigned SKID_STATE_W = 2;

  localparam logic [SKID_STATE_W-1:0] ST_ENC_EMPTY = 2'd0;
  localparam logic [SKID_STATE_W-1:0] ST_ENC_BUSY  = 2'd1;
  localparam logic [SKID_STATE_W-1:0] ST_ENC_FULL  = 2'd2;

  typedef enum logic [SKID_STATE_W-1:0] {
    EMPTY = ST_ENC_EMPTY,
    BUSY  = ST_ENC_BUSY,
    FULL  = ST_ENC_FULL
  } skid_state_t;

endpackage

// File: rtl/register_en_sync_rst.sv
// Enabled data register with synchronous, active-high reset to zero.
// Ports:
//   clk  clock (posedge)
//   rst  synchronous reset, clears q
//   en   load enable; q holds when low
//   din  data to load
//   q    registered data
module register_en_sync_rst #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= din;
    end
  end

endmodule

// File: rtl/register_slice_skid.sv
// Valid/ready register slice with a 2-entry skid buffer. Every output is decoded from
// flops (s_ready additionally gated by rst), so no combinational path crosses the slice,
// yet one beat per cycle is sustained.
// Ports:
//   clk, rst   clock (posedge), synchronous active-high reset
//   s_valid/s_ready/s_data   upstream handshake and payload
//   m_valid/m_ready/m_data   downstream handshake and payload
//   stall_cnt  saturating count of cycles with m_valid & ~m_ready
//              (only when REG_SLICE_STALL_CNT_EN is defined)
// Build option: define REG_SLICE_STALL_CNT_EN to add the stall counter and its port.
module register_slice_skid
  import svlib_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 1
`ifdef REG_SLICE_STALL_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef REG_SLICE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  skid_state_t      state;
  logic             s_fire;
  logic             m_fire;
  logic             load_main;
  logic             load_skid;
  logic [WIDTH-1:0] main_din;
  logic [WIDTH-1:0] skid_data;

  // Decoded from the state flop only; rst gating keeps the producer off during reset.
  assign s_ready = ~rst & (state != FULL);
  assign m_valid = (state != EMPTY);
  assign s_fire  = s_valid & s_ready;
  assign m_fire  = m_valid & m_ready;

  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    case (state)
      EMPTY: load_main = s_fire;
      BUSY: begin
        load_main = s_fire & m_fire;
        load_skid = s_fire & ~m_fire;
      end
      FULL:    load_main = m_fire;
      default: ;
    endcase
  end

  // When draining FULL, the older beat waiting in skid moves up to main.
  assign main_din = (state == FULL) ? skid_data : s_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (s_fire) state <= BUSY;
        BUSY: begin
          if (s_fire && !m_fire) begin
            state <= FULL;
          end else if (!s_fire && m_fire) begin
            state <= EMPTY;
          end
        end
        FULL:    if (m_fire) state <= BUSY;
        default: state <= EMPTY;
      endcase
    end
  end

  register_en_sync_rst #(
    .WIDTH (WIDTH)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (load_main),
    .din (main_din),
    .q   (m_data)
  );

  register_en_sync_rst #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (load_skid),
    .din (s_data),
    .q   (skid_data)
  );

`ifdef REG_SLICE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
